// File: rtl/hmac_sha256_iter.sv
// Iterated HMAC-SHA256 / PBKDF2 F-function; `HMAC_SHA256_ITER_ABORT_EN adds an abort_i port.
// Latency: N * (2 * hasher latency + 5) + 1 cycles from accept to v_o.
// Backpressure: one job in flight, r_o low while busy; v_o/prf_o held until r_i.

module sha256_1024in (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [255:0]  out_digest
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} hstate_t;
    hstate_t state, state_nxt;

    logic [31:0]  h  [8];
    logic [31:0]  v  [8];
    logic [31:0]  vn [8];
    logic [31:0]  w  [16];
    logic [511:0] blk2;
    logic [5:0]   rnd;
    logic         second;
    logic [31:0]  s0, s1, ch, maj, t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One compression round per cycle; w[0] is the schedule word for this round.
    always_comb begin
        s1    = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
        ch    = (v[4] & v[5]) ^ (~v[4] & v[6]);
        t1    = v[7] + s1 + ch + K[rnd] + w[0];
        s0    = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
        maj   = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t2    = s0 + maj;
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        vn[0] = t1 + t2;
        vn[1] = v[0];
        vn[2] = v[1];
        vn[3] = v[2];
        vn[4] = v[3] + t1;
        vn[5] = v[4];
        vn[6] = v[5];
        vn[7] = v[6];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_RUN;
            S_RUN:   if (rnd == 6'd63 && second) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_digest = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                h[i] <= '0;
                v[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w[i] <= '0;
            blk2   <= '0;
            rnd    <= '0;
            second <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            for (int i = 0; i < 8; i++) begin
                h[i] <= IV[255-32*i -: 32];
                v[i] <= IV[255-32*i -: 32];
            end
            for (int i = 0; i < 16; i++) w[i] <= in_data[1023-32*i -: 32];
            blk2   <= in_data[511:0];
            rnd    <= '0;
            second <= 1'b0;
        end else if (state == S_RUN) begin
            rnd <= rnd + 6'd1;
            if (rnd == 6'd63) begin
                // Fold the block into the chaining value and start the second block from it.
                for (int i = 0; i < 8; i++) begin
                    h[i] <= h[i] + vn[i];
                    v[i] <= h[i] + vn[i];
                end
                for (int i = 0; i < 16; i++) w[i] <= blk2[511-32*i -: 32];
                second <= 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) v[i] <= vn[i];
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
            end
        end
    end
endmodule

module hmac_sha256_iter #(
    parameter int ITER_W        = 16,
    parameter int MAX_MSG_BYTES = 55
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      key_i,
    input  logic [511:0]      msg_i,
    input  logic [5:0]        msg_len_i,
    input  logic [ITER_W-1:0] iter_i,
    input  logic              v_i,
    output logic              r_o,
    output logic [255:0]      prf_o,
    output logic              v_o,
    input  logic              r_i,
`ifdef HMAC_SHA256_ITER_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_cnt_o
);
    localparam logic [511:0] IPAD = {64{8'h36}};
    localparam logic [511:0] OPAD = {64{8'h5c}};

    typedef enum logic [2:0] {IDLE, IN_LOAD, IN_WAIT, OUT_LOAD, OUT_WAIT, ACC, DONE} state_t;
    state_t state, state_nxt;

    logic [511:0]      key_q, blk_q, blk_first;
    logic [ITER_W-1:0] n_q, cnt_q;
    logic [255:0]      u_q, acc_q, prf_q;
    logic [5:0]        len_c;
    logic              abt;

    logic              h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [1023:0]     h_in_data;
    logic [255:0]      h_digest;

`ifdef HMAC_SHA256_ITER_ABORT_EN
    logic abort_q;
    assign abt = abort_q | abort_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE)                  abort_q <= 1'b0;
        else if (abort_i && state != DONE)           abort_q <= 1'b1;
    end
`else
    assign abt = 1'b0;
`endif

    // First inner block: message bytes below len, 80h marker, zeros, 64-bit bit length.
    always_comb begin
        len_c     = (msg_len_i > 6'(MAX_MSG_BYTES)) ? 6'(MAX_MSG_BYTES) : msg_len_i;
        blk_first = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(len_c))       blk_first[511-8*i -: 8] = msg_i[511-8*i -: 8];
            else if (i == int'(len_c)) blk_first[511-8*i -: 8] = 8'h80;
        end
        blk_first[63:0] = 64'd512 + {55'd0, len_c, 3'd0};
    end

    // Every later block hashes a 32-byte digest, so its padding is fixed.
    assign h_in_data = {key_q ^ ((state == OUT_LOAD) ? OPAD : IPAD),
                        (state == IN_LOAD && cnt_q == '0) ? blk_q
                                                         : {u_q, 8'h80, 184'd0, 64'd768}};

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        h_in_valid  = 1'b0;
        h_out_ready = 1'b0;
        case (state)
            IDLE: if (v_i) state_nxt = IN_LOAD;
            IN_LOAD, OUT_LOAD: begin
                h_in_valid = !abt;
                if (abt)             state_nxt = IDLE;
                else if (h_in_ready) state_nxt = (state == IN_LOAD) ? IN_WAIT : OUT_WAIT;
            end
            IN_WAIT, OUT_WAIT: begin
                h_out_ready = h_out_valid;
                if (h_out_valid) begin
                    if (abt)                   state_nxt = IDLE;
                    else if (state == IN_WAIT) state_nxt = OUT_LOAD;
                    else                       state_nxt = ACC;
                end
            end
            ACC: begin
                if (abt)                 state_nxt = IDLE;
                else if (cnt_q == n_q)   state_nxt = DONE;
                else                     state_nxt = IN_LOAD;
            end
            DONE: if (r_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q <= '0;
            blk_q <= '0;
            n_q   <= '0;
            cnt_q <= '0;
            u_q   <= '0;
            acc_q <= '0;
            prf_q <= '0;
        end else begin
            case (state)
                IDLE: if (v_i) begin
                    key_q <= key_i;
                    blk_q <= blk_first;
                    n_q   <= (iter_i == '0) ? ITER_W'(1) : iter_i;
                    cnt_q <= '0;
                end
                IN_WAIT: if (h_out_valid) u_q <= h_digest;
                OUT_WAIT: if (h_out_valid) begin
                    u_q   <= h_digest;
                    acc_q <= (cnt_q == '0) ? h_digest : (acc_q ^ h_digest);
                    cnt_q <= cnt_q + ITER_W'(1);
                end
                ACC: if (!abt && cnt_q == n_q) prf_q <= acc_q;
                default: ;
            endcase
            // Only an abort leaves a working state straight for IDLE.
            if (state != IDLE && state != DONE && state_nxt == IDLE) cnt_q <= '0;
        end
    end

    assign r_o        = (state == IDLE) && !rst_i;
    assign v_o        = (state == DONE);
    assign busy_o     = (state != IDLE);
    assign prf_o      = prf_q;
    assign iter_cnt_o = cnt_q;

    sha256_1024in u_sha (
        .clk        (clk_i),
        .rst        (rst_i),
        .in_valid   (h_in_valid),
        .in_ready   (h_in_ready),
        .in_data    (h_in_data),
        .out_valid  (h_out_valid),
        .out_ready  (h_out_ready),
        .out_digest (h_digest)
    );
endmodule

// File: tb/tb_hmac_sha256_iter.sv
// Bench for hmac_sha256_iter: known HMAC/PBKDF2 vectors plus random jobs against a
// byte-level SHA-256/HMAC model; abort scenario only when HMAC_SHA256_ITER_ABORT_EN is defined.

module tb_hmac_sha256_iter;
    typedef logic [7:0] bq_t [$];

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] key = '0;
    logic [511:0] msg = '0;
    logic [5:0]   msg_len = '0;
    logic [15:0]  iter = '0;
    logic         v_in = 1'b0;
    logic         r_out;
    logic [255:0] prf;
    logic         v_out;
    logic         r_in = 1'b0;
    logic         busy;
    logic [15:0]  iter_cnt;
`ifdef HMAC_SHA256_ITER_ABORT_EN
    logic         abort = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    hmac_sha256_iter #(.ITER_W(16), .MAX_MSG_BYTES(55)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_i      (key),
        .msg_i      (msg),
        .msg_len_i  (msg_len),
        .iter_i     (iter),
        .v_i        (v_in),
        .r_o        (r_out),
        .prf_o      (prf),
        .v_o        (v_out),
        .r_i        (r_in),
`ifdef HMAC_SHA256_ITER_ABORT_EN
        .abort_i    (abort),
`endif
        .busy_o     (busy),
        .iter_cnt_o (iter_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input bq_t msg_b);
        bq_t         m;
        logic [31:0] hh [8];
        logic [31:0] w  [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [63:0] nbits;
        m     = msg_b;
        nbits = 64'(msg_b.size()) << 3;
        hh    = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        m.push_back(8'h80);
        while ((m.size() % 64) != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(nbits[8*i +: 8]);
        for (int bk = 0; bk < m.size() / 64; bk++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16)
                    w[t] = {m[64*bk+4*t], m[64*bk+4*t+1], m[64*bk+4*t+2], m[64*bk+4*t+3]};
                else
                    w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                         + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            {a, b, c, d, e, f, g, h} = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
            for (int t = 0; t < 64; t++) begin
                t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
            hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    function automatic logic [255:0] hmac(input logic [511:0] k, input bq_t m);
        bq_t          ib, ob;
        logic [255:0] d;
        for (int i = 0; i < 64; i++) ib.push_back(k[511-8*i -: 8] ^ 8'h36);
        for (int i = 0; i < m.size(); i++) ib.push_back(m[i]);
        d = sha256(ib);
        for (int i = 0; i < 64; i++) ob.push_back(k[511-8*i -: 8] ^ 8'h5c);
        for (int i = 0; i < 32; i++) ob.push_back(d[255-8*i -: 8]);
        return sha256(ob);
    endfunction

    function automatic logic [255:0] prf_model(input logic [511:0] k, input logic [511:0] m,
                                               input int len, input int n);
        bq_t          mb;
        logic [255:0] u, t;
        int           l, nn;
        l  = (len > 55) ? 55 : len;
        nn = (n == 0) ? 1 : n;
        for (int i = 0; i < l; i++) mb.push_back(m[511-8*i -: 8]);
        u = hmac(k, mb);
        t = u;
        for (int j = 2; j <= nn; j++) begin
            mb.delete();
            for (int i = 0; i < 32; i++) mb.push_back(u[255-8*i -: 8]);
            u = hmac(k, mb);
            t ^= u;
        end
        return t;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [511:0] k, input logic [511:0] m,
                             input logic [5:0] len, input logic [15:0] n);
        int t;
        t = 0;
        @(negedge clk);
        key = k; msg = m; msg_len = len; iter = n; v_in = 1'b1;
        while (!r_out && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 256'(r_out), 256'd1);
        @(negedge clk);
        v_in = 1'b0;
        key = rand512(); msg = rand512();
        msg_len = 6'($urandom); iter = 16'($urandom);
    endtask

    task automatic wait_vo(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = v_out;
        end
    endtask

    task automatic run_job(input logic [511:0] k, input logic [511:0] m, input logic [5:0] len,
                           input logic [15:0] n, output logic [255:0] p, output logic [15:0] c);
        bit got;
        start_job(k, m, len, n);
        wait_vo(((n == 0) ? 1 : int'(n)) * 300 + 50, got);
        chk("result_timeout", 256'(got), 256'd1);
        p = prf;
        c = iter_cnt;
        r_in = 1'b1;
        @(negedge clk);
        r_in = 1'b0;
    endtask

    initial begin
        logic [255:0] p, p0, e;
        logic [15:0]  c;
        logic [511:0] k, m, m2;
        logic [5:0]   l;
        logic [15:0]  n;
        bit           seen;

        // Reset
        repeat (3) @(negedge clk);
        chk("r_o_in_reset", 256'(r_out), 256'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_r_o", 256'(r_out), 256'd1);
        chk("rst_v_o", 256'(v_out), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_prf", prf, 256'd0);
        chk("rst_cnt", 256'(iter_cnt), 256'd0);

        // Known vectors
        k = {"Jefe", 480'd0};
        m = {"what do ya want for nothing?", 288'd0};
        run_job(k, m, 6'd28, 16'd1, p, c);
        chk("jefe_hmac", p, 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843);
        chk("jefe_cnt", 256'(c), 256'd1);
        chk("prf_holds", prf, 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843);

        k = {"password", 448'd0};
        m = {"salt", 32'h00000001, 448'd0};
        run_job(k, m, 6'd8, 16'd1, p, c);
        chk("pbkdf2_n1", p, 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b);
        run_job(k, m, 6'd8, 16'd2, p, c);
        chk("pbkdf2_n2", p, 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43);
        chk("pbkdf2_n2_cnt", 256'(c), 256'd2);
        chk("model_n2", prf_model(k, m, 8, 2), 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43);
        run_job(k, m, 6'd8, 16'd0, p, c);
        chk("pbkdf2_n0", p, 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b);
        chk("pbkdf2_n0_cnt", 256'(c), 256'd1);

        // Over-long length with nonzero tail bytes behaves as length 55
        k = rand512();
        m = rand512();
        m[71:64] = 8'ha5;
        m2 = m & {{440{1'b1}}, 72'd0};
        run_job(k, m, 6'd63, 16'd1, p, c);
        chk("len63_clamp", p, prf_model(k, m2, 55, 1));

        // Random jobs
        for (int i = 0; i < 4; i++) begin
            k = rand512();
            m = rand512();
            l = 6'($urandom_range(0, 55));
            n = 16'($urandom_range(1, 3));
            run_job(k, m, l, n, p, c);
            chk("rand_prf", p, prf_model(k, m, int'(l), int'(n)));
            chk("rand_cnt", 256'(c), 256'(n));
        end

        // Backpressure: result held, new request ignored until consumed
        k = rand512(); m = rand512(); l = 6'd20;
        start_job(k, m, l, 16'd1);
        chk("busy_running", 256'(busy), 256'd1);
        wait_vo(400, seen);
        chk("bp_timeout", 256'(seen), 256'd1);
        p0 = prf;
        chk("bp_prf", p0, prf_model(k, m, 20, 1));
        m2 = rand512();
        key = k; msg = m2; msg_len = 6'd33; iter = 16'd1; v_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_v_o", 256'(v_out), 256'd1);
            chk("bp_prf_stable", prf, p0);
            chk("bp_r_o", 256'(r_out), 256'd0);
        end
        r_in = 1'b1;
        @(negedge clk);
        r_in = 1'b0;
        chk("bp_idle_r_o", 256'(r_out), 256'd1);
        @(negedge clk);
        v_in = 1'b0;
        key = rand512(); msg = rand512();
        wait_vo(400, seen);
        chk("bp2_timeout", 256'(seen), 256'd1);
        chk("bp2_prf", prf, prf_model(k, m2, 33, 1));
        r_in = 1'b1;
        @(negedge clk);
        r_in = 1'b0;

        // Reset while the outer hash of the first iteration is in flight
        k = rand512(); m = rand512();
        start_job(k, m, 6'd10, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            seen = seen | v_out;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_r_o", 256'(r_out), 256'd0);
        seen = seen | v_out;
        rst = 1'b0;
        @(negedge clk);
        seen = seen | v_out;
        chk("midrst_no_v_o", 256'(seen), 256'd0);
        chk("midrst_r_o_after", 256'(r_out), 256'd1);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_cnt", 256'(iter_cnt), 256'd0);
        chk("midrst_prf", prf, 256'd0);
        k = rand512(); m = rand512();
        run_job(k, m, 6'd45, 16'd2, p, c);
        chk("post_rst_prf", p, prf_model(k, m, 45, 2));

`ifdef HMAC_SHA256_ITER_ABORT_EN
        // Abort a long job early, then run a known vector
        p0 = prf;
        k = rand512(); m = rand512();
        start_job(k, m, 6'd12, 16'd100);
        seen = 1'b0;
        for (int i = 0; i < 3 * 264; i++) begin
            @(negedge clk);
            seen = seen | v_out;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 600 && busy; i++) begin
            @(negedge clk);
            seen = seen | v_out;
        end
        chk("abort_busy_low", 256'(busy), 256'd0);
        chk("abort_no_v_o", 256'(seen), 256'd0);
        chk("abort_cnt", 256'(iter_cnt), 256'd0);
        chk("abort_prf", prf, p0);
        run_job({"Jefe", 480'd0}, {"what do ya want for nothing?", 288'd0}, 6'd28, 16'd1, p, c);
        chk("after_abort", p, 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hmac_sha256_iter.md
Name: hmac_sha256_iter

Overview:
- Parametrised iterated HMAC-SHA256 engine; the next-generation HMAC core and the inner loop of the PBKDF2 top level.
- Computes U1 = HMAC(K, M) and Uj = HMAC(K, U(j-1)) for j = 2..N, and returns T = U1 ^ U2 ^ ... ^ UN (the PBKDF2 F-function for one output block).
- N = 1 gives plain HMAC-SHA256.
- Drives one sha256_1024in instance through its valid/ready handshake.

Parameters:
- ITER_W, 16, width of the iteration count input.
- MAX_MSG_BYTES, 55, largest accepted message length in bytes; must be ≤ 55 (one 512-bit block after ipad).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- key_i  in  512  key, left aligned, zero filled; keys longer than 64 bytes are pre-hashed upstream
- msg_i  in  512  first message, left aligned, zero filled; caller appends the PBKDF2 INT(i)
- msg_len_i  in  6  message length in bytes
- iter_i  in  ITER_W  iteration count N; 0 treated as 1
- v_i  in  1  request valid
- r_o  out  1  ready to accept request
- prf_o  out  256  accumulated result T
- v_o  out  1  result valid
- r_i  in  1  downstream ready
- busy_o  out  1  high from accept until result consumed
- iter_cnt_o  out  ITER_W  iterations completed in current job

Behaviour:
- Reset (synchronous, active-high; also resets the hasher):
  - State returns to IDLE.
  - r_o=0 during reset and 1 from the first cycle after.
  - v_o=0, busy_o=0, prf_o=0, iter_cnt_o=0. Internal key, message and accumulator registers are cleared.
- Reset mid-operation: the job is dropped, no v_o, and the engine is back in IDLE next cycle.
- Acceptance:
  - r_o=1 only in IDLE; transfer occurs on v_i & r_o.
  - key_i, msg_i, msg_len_i and iter_i are registered at transfer; inputs are don't-care afterwards.
  - msg_len_i > MAX_MSG_BYTES is clamped to MAX_MSG_BYTES.
- Hash block construction:
  - Inner, first iteration: {key^{64{36h}}, msg, 80h at byte msg_len, zeros, 64-bit length 512+8*msg_len}. Message bytes past msg_len are masked to 0 regardless of input.
  - Inner, j ≥ 2: {key^{64{36h}}, U(j-1), 80h, zeros, 64'd768}.
  - Outer, all iterations: {key^{64{5ch}}, inner digest, 80h, zeros, 64'd768}.
- States:
  - IDLE → IN_LOAD on accept.
  - IN_LOAD: hold in_valid with a stable block until in_ready → IN_WAIT.
  - IN_WAIT: on out_valid, pulse out_ready one cycle, capture digest → OUT_LOAD.
  - OUT_LOAD: as IN_LOAD → OUT_WAIT.
  - OUT_WAIT: on out_valid, capture Uj, acc <= (j==1 ? Uj : acc^Uj), iter_cnt_o+1 → ACC.
  - ACC: if iter_cnt_o == N → DONE, else → IN_LOAD with Uj as the message.
  - DONE: prf_o=acc, v_o=1 held stable until r_i; on v_o & r_i → IDLE next cycle.
- Latency per iteration = 2·(hasher latency) + 5 cycles of overhead. Accept-to-v_o = N·that + 1.
- v_i while busy is ignored (r_o=0).
- iter_cnt_o wraps never: the width ITER_W bounds N ≤ 2^ITER_W−1.
- prf_o updates only on entry to DONE. Between jobs it holds the last result.

Optional Feature:
- Macro: HMAC_SHA256_ITER_ABORT_EN
- Defined: adds port abort_i (in, 1).
  - abort_i high in any state other than IDLE/DONE sets a sticky abort flag.
  - Any in-flight hasher digest is drained: wait for out_valid, pulse out_ready.
  - The engine then returns to IDLE without asserting v_o. prf_o is unchanged and iter_cnt_o is cleared.
  - abort_i in IDLE or DONE has no effect.
- Undefined: no abort_i port; jobs always run to completion.

Test Plan:
- Key "Jefe" (4 bytes), msg "what do ya want for nothing?" (len 28), N=1 → prf_o=5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843.
- Key "password", msg "salt"||00000001 (len 8), N=1 → 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b. Same request with N=2 → ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
- Same request with N=4096 → c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a; iter_cnt_o=4096 at v_o.
- N=0 → same result as N=1. msg_len_i=63 with nonzero tail bytes → identical to len 55 with the same first 55 bytes.
- Backpressure: r_i=0 for 20 cycles → v_o and prf_o stable; v_i held high with new data ignored until after r_i. Reset asserted during OUT_WAIT → no v_o, r_o=1 the cycle after reset deasserts, and the next job is correct.
- With HMAC_SHA256_ITER_ABORT_EN: abort_i pulsed at iteration 3 of N=100 → no v_o, busy_o falls after the drain, and the following N=1 job matches its vector.
